image_capture: RTL and testbench
================================

// Module: image_capture
// PURPOSE
//   Writer-side counterpart to the image loading path: accepts a raster-order pixel stream
//   over a valid/ready handshake and assembles it into a 28x28 signed 8-bit frame buffer.
//   Presents the completed frame to the classifier with image_loaded, then holds it until
//   the consumer acknowledges. Sits between the pixel source (UART/canvas front end) and the CNN.
// PARAMETERS
//   IMG_H   28  frame rows
//   IMG_W   28  frame columns
//   PIX_W   8   pixel width in bits; the stored pixel is the raw stream byte, read as signed
// PORTS
//   clk           in   1                    system clock, rising edge
//   reset_n       in   1                    asynchronous, active-low reset
//   s_valid       in   1                    source has a pixel on s_data
//   s_ready       out  1                    block accepts a pixel this cycle
//   s_data        in   PIX_W                pixel value, raster order (row-major, col fastest)
//   s_last        in   1                    source marks final pixel of frame; qualified by s_valid
//   frame_ack     in   1                    consumer done with frame; honoured only in HOLD
//   output_image  out  PIX_W x IMG_H x IMG_W  signed frame buffer [row][col]
//   image_loaded  out  1                    frame complete and stable (level)
//   frame_err     out  1                    one-cycle pulse on framing error
//   pix_count     out  10                   pixels accepted in current frame (0..783)
// BEHAVIOUR
//   - Reset (reset_n=0, async assert, sync release): state=IDLE, s_ready=0 while in reset,
//     image_loaded=0, frame_err=0, pix_count=0, row/col=0, all output_image entries = 0.
//   - Beat accepted when s_valid && s_ready at a rising clk; s_data written to
//     output_image[row][col]; col++, at col==IMG_W-1 col wraps to 0 and row++.
//   - States:
//     IDLE : s_ready=1. First accepted beat -> FILL (or HOLD if single-pixel frame size).
//     FILL : s_ready=1. Accept beats until index IMG_H*IMG_W-1 is written -> HOLD.
//     HOLD : s_ready=0, image_loaded=1, output_image frozen. frame_ack=1 -> IDLE.
//   - Latency: image_loaded rises the cycle after the final beat is accepted; s_ready falls
//     the same cycle. After frame_ack sampled in HOLD, image_loaded=0 and s_ready=1 next cycle.
//   - s_last on final beat (index 783): normal completion, no error.
//   - Short frame: s_last on a beat with index < 783 -> that pixel is written, frame_err
//     pulses 1 cycle, row/col/pix_count clear, state -> IDLE, image_loaded stays 0.
//     Buffer holds partial data; it is not guaranteed valid and is overwritten by next frame.
//   - Long frame: final beat without s_last -> HOLD entered normally, image_loaded=1, and
//     frame_err pulses 1 cycle; excess source pixels stall (s_ready=0) until frame_ack.
//   - frame_ack outside HOLD is ignored. s_last without s_valid is ignored.
//   - No beat can be accepted in HOLD, so ack and a new beat never coincide.
//   - Buffer contents persist across IDLE until overwritten pixel-by-pixel by the next frame.
//   - pix_count = beats accepted in current frame; 784 is never shown (frame holds at 783
//     in HOLD); clears to 0 on exit from HOLD or on short-frame abort.
//   - reset_n assertion mid-frame: immediate abort, all state and buffer to reset values.
// TESTING
//   1 Full frame, s_valid=1 continuous, s_data=index mod 256, s_last on 783 -> image_loaded
//     at cycle 785 after first beat; [0][0]=8'h00, [14][14]=8'h96, [27][27]=8'h0F; frame_err=0.
//   2 Same frame with random s_valid gaps (~50%) -> identical buffer, image_loaded only after
//     beat 783, no dropped or duplicated pixels.
//   3 s_last on beat 99 -> frame_err high exactly 1 cycle, image_loaded=0, pix_count=0;
//     following full frame of 8'h55 completes with every pixel = 8'h55.
//   4 784 beats without s_last, source keeps s_valid=1 -> image_loaded=1, frame_err 1-cycle
//     pulse, s_ready=0 held; frame_ack -> s_ready=1 next cycle, 785th pixel lands at [0][0].
//   5 In HOLD hold frame_ack=0 for 50 cycles with s_valid=1 -> buffer unchanged, s_ready=0;
//     frame_ack pulse in IDLE -> no state change.
//   6 reset_n low mid-beat at index 400 -> outputs 0 asynchronously, buffer all 0;
//     after release, full frame captures correctly from [0][0].

Source files
------------

// File: rtl/image_capture_if.sv
// -----------------------------------------------------------------------------
// image_capture_if
//   Valid/ready pixel stream between the pixel source (UART/canvas front end)
//   and image_capture. A beat transfers when s_valid and s_ready are both high
//   at a rising clock edge.
//
//   Signals
//     s_valid  source -> sink  a pixel is present on s_data
//     s_ready  sink -> source  sink accepts a pixel this cycle
//     s_data   source -> sink  pixel byte, raster order (row-major)
//     s_last   source -> sink  final pixel of frame, qualified by s_valid
//
//   Modports
//     master   pixel source
//     slave    frame capture block
// -----------------------------------------------------------------------------
interface image_capture_if #(
   parameter int PIX_W = 8
);
   logic             s_valid;
   logic             s_ready;
   logic [PIX_W-1:0] s_data;
   logic             s_last;

   modport master (
      output s_valid,
      output s_data,
      output s_last,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data,
      input  s_last,
      output s_ready
   );
endinterface

// File: rtl/image_capture.sv
// -----------------------------------------------------------------------------
// image_capture
//   Assembles a raster-order pixel stream into an IMG_H x IMG_W frame buffer
//   and presents the completed frame to the classifier until it is acknowledged.
//
//   Ports
//     clk           in   system clock, rising edge
//     reset_n       in   asynchronous active-low reset
//     s             --   pixel stream (image_capture_if.slave)
//     frame_ack     in   consumer finished with the frame; honoured only in HOLD
//     output_image  out  frame buffer [row][col]; each byte is a signed pixel
//     image_loaded  out  frame complete and stable (level)
//     frame_err     out  one-cycle pulse on a short or long frame
//     pix_count     out  pixels accepted in the current frame (0..IMG_H*IMG_W-1)
//
//   States
//     IDLE  waiting for the first pixel of a frame, s_ready high
//     FILL  frame in progress, s_ready high
//     HOLD  frame complete, s_ready low, buffer frozen until frame_ack
// -----------------------------------------------------------------------------
module image_capture #(
   parameter int IMG_H = 28,
   parameter int IMG_W = 28,
   parameter int PIX_W = 8
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   image_capture_if.slave                        s,
   input  logic                                  frame_ack,
   output logic [IMG_H-1:0][IMG_W-1:0][PIX_W-1:0] output_image,
   output logic                                  image_loaded,
   output logic                                  frame_err,
   output logic [9:0]                            pix_count
);

   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [9:0]       LAST_IDX = 10'(IMG_H * IMG_W - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FILL = 2'b01,
      HOLD = 2'b10
   } state_t;

   state_t                                 state_r, state_s;
   logic [ROW_W-1:0]                       row_r, row_s;
   logic [COL_W-1:0]                       col_r, col_s;
   logic [9:0]                             cnt_r, cnt_s;
   logic                                   ready_r, ready_s;
   logic                                   loaded_r, loaded_s;
   logic                                   err_r, err_s;
   logic                                   beat_s;
   logic [IMG_H-1:0][IMG_W-1:0][PIX_W-1:0] buf_r;

   // ready_r is low throughout HOLD, so no beat can land while the frame is frozen
   assign beat_s = s.s_valid && ready_r;

   // Next-state, raster position and registered-output decode
   always_comb begin
      state_s = state_r;
      row_s   = row_r;
      col_s   = col_r;
      cnt_s   = cnt_r;
      err_s   = 1'b0;
      case (state_r)
         IDLE, FILL: begin
            if (beat_s) begin
               if (cnt_r == LAST_IDX) begin
                  // Final pixel: complete the frame; a missing s_last is a long frame.
                  // The count stays at the last index so the full size is never shown.
                  state_s = HOLD;
                  err_s   = !s.s_last;
               end else if (s.s_last) begin
                  // Short frame: the pixel is written, then the frame is abandoned
                  state_s = IDLE;
                  row_s   = '0;
                  col_s   = '0;
                  cnt_s   = 10'd0;
                  err_s   = 1'b1;
               end else begin
                  state_s = FILL;
                  cnt_s   = cnt_r + 10'd1;
                  if (col_r == LAST_COL) begin
                     col_s = '0;
                     row_s = row_r + ROW_W'(1);
                  end else begin
                     col_s = col_r + COL_W'(1);
                  end
               end
            end else begin
               state_s = state_r;
            end
         end
         HOLD: begin
            if (frame_ack) begin
               state_s = IDLE;
               row_s   = '0;
               col_s   = '0;
               cnt_s   = 10'd0;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s = IDLE;
            row_s   = '0;
            col_s   = '0;
            cnt_s   = 10'd0;
         end
      endcase
      ready_s  = (state_s != HOLD);
      loaded_s = (state_s == HOLD);
   end

   // State, position and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= IDLE;
         row_r    <= '0;
         col_r    <= '0;
         cnt_r    <= 10'd0;
         ready_r  <= 1'b0;
         loaded_r <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         state_r  <= state_s;
         row_r    <= row_s;
         col_r    <= col_s;
         cnt_r    <= cnt_s;
         ready_r  <= ready_s;
         loaded_r <= loaded_s;
         err_r    <= err_s;
      end
   end

   // Frame buffer: each accepted beat lands at the current raster position
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_r <= '0;
      end else if (beat_s) begin
         buf_r[row_r][col_r] <= s.s_data;
      end
   end

   assign s.s_ready    = ready_r;
   assign output_image = buf_r;
   assign image_loaded = loaded_r;
   assign frame_err    = err_r;
   assign pix_count    = cnt_r;

endmodule

// File: tb/tb_image_capture.sv
// -----------------------------------------------------------------------------
// tb_image_capture
//   Drives randomized and directed pixel streams into image_capture and
//   compares every cycle against a frame-level reference model (pixel index,
//   hold flag, expected image array).
// -----------------------------------------------------------------------------
module tb_image_capture;

   localparam int NPIX = 784;

   logic                     clk;
   logic                     reset_n;
   logic                     frame_ack;
   logic [27:0][27:0][7:0]   output_image;
   logic                     image_loaded;
   logic                     frame_err;
   logic [9:0]               pix_count;

   image_capture_if #(.PIX_W(8)) s_if ();

   image_capture #(.IMG_H(28), .IMG_W(28), .PIX_W(8)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s            (s_if),
      .frame_ack    (frame_ack),
      .output_image (output_image),
      .image_loaded (image_loaded),
      .frame_err    (frame_err),
      .pix_count    (pix_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: pixel index within frame, frame-complete flag, image
   logic [7:0] m_img [NPIX];
   int         m_count;
   bit         m_hold;
   bit         m_ready;
   bit         m_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NPIX; i++) m_img[i] = 8'h00;
      m_count = 0;
      m_hold  = 1'b0;
      m_ready = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, "_ready"},  32'(s_if.s_ready), 32'(m_ready));
      check_eq({tag, "_loaded"}, 32'(image_loaded), 32'(m_hold));
      check_eq({tag, "_err"},    32'(frame_err),    32'(m_err));
      check_eq({tag, "_count"},  32'(pix_count),    32'(m_count));
   endtask

   task automatic compare_buf(input string tag);
      for (int r = 0; r < 28; r++) begin
         for (int c = 0; c < 28; c++) begin
            check_eq($sformatf("%s[%0d][%0d]", tag, r, c),
                     32'(output_image[r][c]), 32'(m_img[r*28 + c]));
         end
      end
   endtask

   // One clock cycle: drive inputs, update model at the edge, check outputs
   task automatic step(input logic v, input logic [7:0] d, input logic l,
                       input logic a, output bit acc);
      s_if.s_valid = v;
      s_if.s_data  = d;
      s_if.s_last  = l;
      frame_ack    = a;
      @(posedge clk);
      acc   = v && m_ready;
      m_err = 1'b0;
      if (acc) begin
         m_img[m_count] = d;
         if (m_count == NPIX - 1) begin
            m_hold = 1'b1;
            m_err  = !l;
         end else if (l) begin
            m_err   = 1'b1;
            m_count = 0;
         end else begin
            m_count++;
         end
      end else if (m_hold && a) begin
         m_hold  = 1'b0;
         m_count = 0;
      end
      m_ready = !m_hold;
      #1;
      check_outputs("cyc");
   endtask

   // Full frame with s_valid continuous; data from a per-index function
   task automatic full_frame(input int mode, input bit with_last);
      bit acc;
      logic [7:0] d;
      for (int i = 0; i < NPIX; i++) begin
         case (mode)
            0:       d = 8'(i);
            1:       d = 8'h55;
            default: d = 8'($urandom_range(0, 255));
         endcase
         step(1'b1, d, with_last && (i == NPIX - 1), 1'b0, acc);
      end
   endtask

   initial begin
      bit acc;
      int sent;
      int guard;
      bit v;

      reset_n      = 1'b0;
      s_if.s_valid = 1'b0;
      s_if.s_data  = 8'h00;
      s_if.s_last  = 1'b0;
      frame_ack    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("rst");
      compare_buf("rst_buf");
      reset_n = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0, acc);

      // 1: continuous full frame, data = index mod 256
      full_frame(0, 1'b1);
      check_eq("t1_loaded", 32'(image_loaded), 32'd1);
      check_eq("t1_00",     32'(output_image[0][0]),   32'h00);
      check_eq("t1_1414",   32'(output_image[14][14]), 32'h96);
      check_eq("t1_2727",   32'(output_image[27][27]), 32'h0F);
      compare_buf("t1_buf");
      step(1'b0, 8'h00, 1'b0, 1'b1, acc);

      // 2: same frame with random s_valid gaps
      sent  = 0;
      guard = 0;
      while (sent < NPIX && guard < 20000) begin
         v = 1'($urandom_range(0, 1));
         step(v, 8'(sent), v && (sent == NPIX - 1), 1'b0, acc);
         if (acc) sent++;
         guard++;
      end
      check_eq("t2_beats", 32'(sent), 32'(NPIX));
      compare_buf("t2_buf");
      step(1'b0, 8'h00, 1'b0, 1'b1, acc);

      // 3: short frame ending on beat 99, then a full frame of 0x55
      for (int i = 0; i < 100; i++) step(1'b1, 8'(i + 3), i == 99, 1'b0, acc);
      check_eq("t3_err",   32'(frame_err), 32'd1);
      check_eq("t3_count", 32'(pix_count), 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0, acc);
      check_eq("t3_err_gone", 32'(frame_err), 32'd0);
      full_frame(1, 1'b1);
      compare_buf("t3_buf");
      step(1'b0, 8'h00, 1'b0, 1'b1, acc);

      // 4/5: long frame, source keeps pushing while held for 50 cycles
      full_frame(2, 1'b0);
      check_eq("t4_err", 32'(frame_err), 32'd1);
      for (int i = 0; i < 50; i++) step(1'b1, 8'hAA, 1'b0, 1'b0, acc);
      check_eq("t4_ready_held", 32'(s_if.s_ready), 32'd0);
      compare_buf("t5_buf");
      step(1'b1, 8'h77, 1'b0, 1'b1, acc);
      check_eq("t4_ready_after_ack", 32'(s_if.s_ready), 32'd1);
      step(1'b1, 8'h77, 1'b0, 1'b0, acc);
      check_eq("t4_pix785", 32'(output_image[0][0]), 32'h77);
      step(1'b1, 8'h12, 1'b1, 1'b0, acc);
      step(1'b0, 8'h00, 1'b0, 1'b1, acc);
      step(1'b0, 8'h00, 1'b0, 1'b0, acc);

      // 6: reset asserted mid-beat at index 400
      for (int i = 0; i < 400; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, acc);
      s_if.s_valid = 1'b1;
      s_if.s_data  = 8'hC3;
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs("t6_rst");
      compare_buf("t6_buf_rst");
      s_if.s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0, acc);
      full_frame(2, 1'b1);
      compare_buf("t6_buf");
      step(1'b0, 8'h00, 1'b0, 1'b1, acc);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
